// File: rtl/phase_max_timer_if.sv
// Load/select/tick handshake between the priority arbiter side and the phase max-time timer.
// The master drives requests and the time base; the slave reports the countdown.
interface phase_max_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [3:0]       sel;
    logic             tick;
    logic             hold;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;
    logic             sel_err;

    modport master (
        output load, sel, tick, hold,
        input  count, busy, expired, sel_err
    );

    modport slave (
        input  load, sel, tick, hold,
        output count, busy, expired, sel_err
    );
endinterface

// File: rtl/phase_max_timer.sv
// Decodes a one-hot max-time select into a phase duration and counts it down on tick,
// pulsing expired at zero and sel_err on a load with a malformed select.
module phase_max_timer #(
    parameter int          WIDTH   = 8,
    parameter logic [31:0] T_EMERG = 32'd5,
    parameter logic [31:0] T_PED   = 32'd20,
    parameter logic [31:0] T_NIGHT = 32'd45,
    parameter logic [31:0] T_DAY   = 32'd30
) (
    input  logic              clk,
    input  logic              rst,
    phase_max_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(32'd1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             expired_q, expired_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_ok_s;
    logic [WIDTH-1:0] load_time_s;

    function automatic logic sel_onehot(input logic [3:0] s);
        return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    endfunction

    // Highest set bit wins, so the decode stays well defined even if called on a bad select.
    function automatic logic [WIDTH-1:0] sel_decode(input logic [3:0] s);
        if (s[3]) begin
            return WIDTH'(T_EMERG);
        end else if (s[2]) begin
            return WIDTH'(T_PED);
        end else if (s[1]) begin
            return WIDTH'(T_NIGHT);
        end else begin
            return WIDTH'(T_DAY);
        end
    endfunction

    assign sel_ok_s    = sel_onehot(bus.sel);
    assign load_time_s = sel_decode(bus.sel);

    // Next-state, next-count and pulse generation; a valid load overrides any tick.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        sel_err_d = 1'b0;
        if (bus.load) begin
            if (sel_ok_s) begin
                count_d   = load_time_s;
                state_d   = (load_time_s == '0) ? DONE : RUN;
                expired_d = (load_time_s == '0);
            end else begin
                sel_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.tick && !bus.hold) begin
                        if (count_q <= ONE) begin
                            count_d   = '0;
                            state_d   = DONE;
                            expired_d = 1'b1;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                DONE: begin
                    count_d = '0;
                end
                IDLE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State, count and pulse registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            expired_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = (state_q == RUN);
    assign bus.expired = expired_q;
    assign bus.sel_err = sel_err_q;

endmodule

// File: tb/tb_phase_max_timer.sv
// Randomized and directed bench for phase_max_timer against a behavioural countdown model.
module tb_phase_max_timer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   check_en = 1'b0;

    // Behavioural model: remaining time and which pulses must be visible this cycle.
    int m_count;
    bit m_busy;
    bit m_exp;
    bit m_err;

    phase_max_timer_if #(.WIDTH(8)) bus ();

    phase_max_timer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int time_for(input logic [3:0] s);
        int tbl [4] = '{30, 45, 20, 5};
        for (int b = 3; b >= 0; b--) begin
            if (s[b]) return tbl[b];
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_busy  = 1'b0;
        m_exp   = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge(input bit l, input logic [3:0] s, input bit t, input bit h);
        m_exp = 1'b0;
        m_err = 1'b0;
        if (l) begin
            if ($countones(s) == 1) begin
                m_count = time_for(s);
                m_busy  = (m_count != 0);
                m_exp   = (m_count == 0);
            end else begin
                m_err = 1'b1;
            end
        end else if (m_busy && t && !h) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_busy = 1'b0;
                m_exp  = 1'b1;
            end
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge with the model updated.
    task automatic step(input bit l, input logic [3:0] s, input bit t, input bit h);
        bus.load = l;
        bus.sel  = s;
        bus.tick = t;
        bus.hold = h;
        @(posedge clk);
        model_edge(l, s, t, h);
        #1;
        bus.load = 1'b0;
        bus.tick = 1'b0;
        bus.hold = 1'b0;
        bus.sel  = 4'd0;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("count",   int'(bus.count),   m_count);
            chk("busy",    int'(bus.busy),    int'(m_busy));
            chk("expired", int'(bus.expired), int'(m_exp));
            chk("sel_err", int'(bus.sel_err), int'(m_err));
        end
    end

    initial begin
        rst      = 1'b1;
        bus.load = 1'b0;
        bus.sel  = 4'd0;
        bus.tick = 1'b0;
        bus.hold = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_count", int'(bus.count), 0);
        chk("reset_busy",  int'(bus.busy),  0);
        check_en = 1'b1;

        // Day countdown from 30 to 0.
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        chk("day_load", int'(bus.count), 30);
        chk("day_busy", int'(bus.busy), 1);
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 4'd0, 1'b1, 1'b0);
            chk("day_count", int'(bus.count), 30 - i);
        end
        chk("day_expired", int'(bus.expired), 1);
        chk("day_busy_end", int'(bus.busy), 0);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("day_expired_once", int'(bus.expired), 0);

        step(1'b1, 4'b1000, 1'b0, 1'b0);
        chk("emerg_load", int'(bus.count), 5);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        chk("ped_load", int'(bus.count), 20);
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("night_load", int'(bus.count), 45);
        step(1'b1, 4'b0000, 1'b0, 1'b0);
        chk("err_zero", int'(bus.sel_err), 1);
        chk("err_zero_count", int'(bus.count), 45);
        step(1'b1, 4'b1100, 1'b0, 1'b0);
        chk("err_multi", int'(bus.sel_err), 1);
        chk("err_multi_busy", int'(bus.busy), 1);

        // Abort a Day timer mid-run with an Emergency load.
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        repeat (10) step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("abort_mid", int'(bus.count), 20);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        chk("abort_reload", int'(bus.count), 5);
        repeat (5) step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("abort_expired", int'(bus.expired), 1);
        repeat (25) step(1'b0, 4'd0, 1'b1, 1'b0);

        // Load coinciding with a tick, and with the final tick.
        step(1'b1, 4'b0001, 1'b1, 1'b0);
        chk("load_tick", int'(bus.count), 30);
        step(1'b1, 4'b1000, 1'b0, 1'b0);
        repeat (4) step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("pre_final", int'(bus.count), 1);
        step(1'b1, 4'b0010, 1'b1, 1'b0);
        chk("final_load_exp", int'(bus.expired), 0);
        chk("final_load_cnt", int'(bus.count), 45);

        // Hold drops ticks.
        repeat (3) step(1'b0, 4'd0, 1'b1, 1'b1);
        chk("hold_count", int'(bus.count), 45);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("hold_resume", int'(bus.count), 44);

        // Asynchronous reset between edges at count 7.
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        repeat (13) step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("pre_rst", int'(bus.count), 7);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_count",   int'(bus.count),   0);
        chk("async_busy",    int'(bus.busy),    0);
        chk("async_expired", int'(bus.expired), 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) step(1'b0, 4'd0, 1'b1, 1'b0);
        chk("idle_ticks", int'(bus.count), 0);

        // Randomized traffic checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] s;
            if ($urandom_range(3, 0) != 0) s = 4'b0001 << $urandom_range(3, 0);
            else                           s = 4'($urandom_range(15, 0));
            step(($urandom_range(11, 0) == 0), s,
                 ($urandom_range(1, 0) == 1), ($urandom_range(4, 0) == 0));
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/phase_max_timer.md
# phase_max_timer

Sequential consumer of the one-hot max-time select produced by the intersection's priority arbiter (Emergency > Pedestrian > Night > Day). On a load request it decodes the select into a per-condition maximum phase time, counts that time down on a slow tick enable, and reports expiry to the traffic-light controller. It is the receiving end of the `loadMaxTimeSelect` interface.

## Interface

Parameters:
- `WIDTH`, 8: counter width in bits.
- `T_EMERG`, 8'd5: max time for select bit 3 (Emergency).
- `T_PED`, 8'd20: max time for select bit 2 (Pedestrian).
- `T_NIGHT`, 8'd45: max time for select bit 1 (DayNight = 1).
- `T_DAY`, 8'd30: max time for select bit 0 (DayNight = 0).

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `load`, in, 1: single-cycle request to (re)start the timer from `sel`.
- `sel`, in, 4: one-hot max-time select from the arbiter.
- `tick`, in, 1: time-base enable, one cycle wide; one tick is one time unit.
- `hold`, in, 1: freezes the countdown while high.
- `count`, out, WIDTH: remaining time units.
- `busy`, out, 1: high while in RUN.
- `expired`, out, 1: one-cycle pulse when the countdown reaches zero.
- `sel_err`, out, 1: one-cycle pulse when `load` is seen with an invalid `sel`.

## Operation

- FSM states:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Select decode, priority bit 3 down to bit 0:
  - Bit 3 selects T_EMERG; bit 2 selects T_PED; bit 1 selects T_NIGHT; bit 0 selects T_DAY.
  - `sel` is invalid when it is 0000 or has more than one bit set.
  - An invalid `sel` with `load` pulses `sel_err`. The load is ignored and state and `count` are unchanged.
- Valid `load`, in any state:
  - `count` <= decoded time.
  - State -> RUN, or DONE if the decoded time is 0.
  - Load always restarts the timer, including mid-run.
- RUN with `tick` and no `hold`:
  - `count` decrements by 1.
  - If `count` is 1, it goes to 0, state -> DONE, and `expired` pulses.
- In RUN, `hold` high blocks decrements; ticks arriving during hold are dropped, not queued.
- DONE: `count` holds at 0 and ticks are ignored. Only `load` or `rst` leave DONE.
- IDLE: `count` = 0, ticks ignored.
- Parameters wider than WIDTH are truncated to WIDTH bits. Decrement never wraps below 0.

## Timing

- Reset values:
  - State = IDLE.
  - `count` = 0, `busy` = 0, `expired` = 0, `sel_err` = 0.
- Asserting `rst` mid-run clears everything immediately, without waiting for `clk`. `expired` does not pulse.
- Load latency is 1 cycle: `load` sampled at edge N gives the new `count` and `busy` = 1 after edge N.
- `expired` and `sel_err` are registered:
  - High for exactly the one cycle after the causing edge.
- Zero-time load: `expired` is high the cycle after the load edge, with `busy` = 0.
- Simultaneous events:
  - `load` together with `tick` on the same edge: load wins and there is no decrement.
  - `load` together with the final tick: load wins and `expired` does not pulse.
- Timer length: from the load edge, `expired` follows the T-th accepted tick, where T is the decoded time.
- `busy` drops on the same edge that raises `expired`.

## Test plan

- Reset, then `load` with `sel` = 0001, then 30 ticks:
  - `count` reads 30, 29, … 1, 0.
  - `expired` is a single pulse after the 30th tick.
  - `busy` is 1 throughout the countdown and 0 after.
- Check each one-hot select in turn:
  - `sel` = 1000, 0100 and 0010 load 5, 20 and 45 respectively.
  - `sel` = 0000 and `sel` = 1100 each pulse `sel_err`, with `count` and state unchanged.
- `load` with 0001, 10 ticks, then `load` with 1000 (`count` = 20, then 5):
  - `expired` follows 5 further ticks.
  - No `expired` pulse from the aborted Day timer.
- `load` and `tick` on the same edge:
  - `count` equals the full decoded value with no decrement.
  - Repeat with the final tick: `expired` stays 0.
- `hold` high across 3 ticks in RUN:
  - `count` is unchanged.
  - After `hold` drops, decrements resume.
- Assert `rst` asynchronously between edges while `count` = 7:
  - Outputs go to 0 before the next edge.
  - State is IDLE, and ticks are ignored afterwards.
